// File: rtl/uart_tx_fifo_if.sv
// Host write-side interface of uart_tx_fifo.
//   master : host side  - drives wr_en/wr_data, observes FIFO status
//   slave  : transmitter - accepts writes, reports full/empty/count/overflow
// FIFO_DEPTH must match the transmitter instance; CNT_W is derived from it.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    modport master (output wr_en, wr_data,
                    input  fifo_full, fifo_empty, fifo_count, overflow);
    modport slave  (input  wr_en, wr_data,
                    output fifo_full, fifo_empty, fifo_count, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/parity/stop framer.
// Frames go out back-to-back while the FIFO holds data.
// Ports:
//   clock, rst              - single clock, asynchronous active-high reset
//   baud_div                - bit period in clocks minus 1
//   data_length             - 00=5 .. 11=8 data bits
//   parity_type             - 01=odd, 10=even, 00/11=none
//   stop_bits               - 0=one, 1=two stop bits
//   host (slave modport)    - wr_en/wr_data in; fifo_full/empty/count, overflow out
//   data_out                - serial line, idle high
//   tx_active               - frame on the line
//   tx_done                 - pulse on the last clock of the final stop bit
// Optional build macro UART_TX_BREAK_EN adds input break_req: while it is high
// and the framer is idle the line is held low and pops are held off; after it
// drops the line stays high for at least one bit period before the next start.
module uart_tx_fifo #(
    parameter  int FIFO_DEPTH = 16,
    parameter  int DIV_W      = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_length,
    input  logic [1:0]       parity_type,
    input  logic             stop_bits,
`ifdef UART_TX_BREAK_EN
    input  logic             break_req,
`endif
    uart_tx_fifo_if.slave    host,
    output logic             data_out,
    output logic             tx_active,
    output logic             tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // ---------------- FIFO ----------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
    logic             push, pop;

    always_comb begin
        push     = host.wr_en && !full_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d   = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
        // Full-time writes are dropped even if a pop frees a slot this cycle.
        ovf_d    = host.wr_en && full_q;
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= host.wr_data;
    end

    assign host.fifo_full  = full_q;
    assign host.fifo_empty = empty_q;
    assign host.fifo_count = count_q;
    assign host.overflow   = ovf_q;

    // ---------------- framer ----------------
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, bdiv_q, bdiv_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic [1:0]       len_q, len_d;
    logic             par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
    logic             tick, blocked, can_pop, load;
    logic [7:0]       head, masked;
`ifdef UART_TX_BREAK_EN
    logic             brk_on_q, brk_on_d, rec_q, rec_d;
`endif

    assign head   = mem_q[rd_ptr_q];
    // Parity only covers the bits actually sent.
    assign masked = head & (8'hFF >> (2'd3 - data_length));
    assign tick   = (cnt_q == '0);
    assign pop    = load;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bdiv_d    = bdiv_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        len_d     = len_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        load      = 1'b0;
        tx_done   = 1'b0;
        blocked   = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_on_d  = 1'b0;
        rec_d     = 1'b0;
        blocked   = break_req || brk_on_q || rec_q;
`endif
        can_pop   = !empty_q && !blocked;

        case (state_q)
            IDLE: begin
                if (can_pop) load = 1'b1;
`ifdef UART_TX_BREAK_EN
                // cnt_q is free while idle, so it times the post-break mark.
                brk_on_d = break_req;
                if (!break_req && brk_on_q) begin
                    rec_d = 1'b1;
                    cnt_d = baud_div;
                end else if (!break_req && rec_q) begin
                    rec_d = !tick;
                    if (!tick) cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    cnt_d   = bdiv_q;
                    bit_d   = '0;
                end else cnt_d = cnt_q - 1'b1;
            end
            DATA: begin
                if (tick) begin
                    cnt_d = bdiv_q;
                    if (bit_q == {1'b0, len_q} + 3'd4) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = sh_q >> 1;
                    end
                end else cnt_d = cnt_q - 1'b1;
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    cnt_d   = bdiv_q;
                    bit_d   = '0;
                end else cnt_d = cnt_q - 1'b1;
            end
            STOP: begin
                if (tick) begin
                    if (stop2_q && bit_q == 3'd0) begin
                        bit_d = 3'd1;
                        cnt_d = bdiv_q;
                    end else begin
                        tx_done = 1'b1;
                        if (can_pop) load = 1'b1;
                        else         state_d = IDLE;
                    end
                end else cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Pop the head and freeze the whole frame configuration.
        if (load) begin
            state_d   = START;
            cnt_d     = baud_div;
            bdiv_d    = baud_div;
            bit_d     = '0;
            sh_d      = head;
            len_d     = data_length;
            par_en_d  = (parity_type == 2'b01) || (parity_type == 2'b10);
            par_bit_d = (^masked) ^ (parity_type == 2'b01);
            stop2_d   = stop_bits;
        end
    end

    always_comb begin
        data_out = 1'b1;
        case (state_q)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                data_out = !break_req;
`endif
            end
            START:   data_out = 1'b0;
            DATA:    data_out = sh_q[0];
            PARITY:  data_out = par_bit_q;
            default: data_out = 1'b1;
        endcase
    end

    assign tx_active = (state_q != IDLE);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bdiv_q    <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            len_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_on_q  <= 1'b0;
            rec_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bdiv_q    <= bdiv_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            len_q     <= len_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
`ifdef UART_TX_BREAK_EN
            brk_on_q  <= brk_on_d;
            rec_q     <= rec_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues the expected line
// sequence of each frame; a monitor captures the line clock by clock while
// tx_active is high and compares on every tx_done pulse.
module tb_uart_tx_fifo;
    logic        clock = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [1:0]  data_length;
    logic [1:0]  parity_type;
    logic        stop_bits;
    logic        data_out, tx_active, tx_done;
`ifdef UART_TX_BREAK_EN
    logic        break_req = 1'b0;
`endif

    uart_tx_fifo_if #(.FIFO_DEPTH(16)) hif ();

    uart_tx_fifo #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
        .clock       (clock),
        .rst         (rst),
        .baud_div    (baud_div),
        .data_length (data_length),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
`ifdef UART_TX_BREAK_EN
        .break_req   (break_req),
`endif
        .host        (hif),
        .data_out    (data_out),
        .tx_active   (tx_active),
        .tx_done     (tx_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        string name;
        string bits;   // line value per bit period, first-sent bit first
        int    div;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   act_cnt = 0, done_cnt = 0, ov_cnt = 0;
    bit   cap [0:1023];
    int   cap_len = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic push_exp(input string name, input string bits, input int div);
        exp_t e;
        e.name = name; e.bits = bits; e.div = div;
        exp_q.push_back(e);
    endtask

    // Start bit, 8 data bits LSB first, one stop bit.
    function automatic string frame8n1(input logic [7:0] b);
        string s = "0";
        for (int i = 0; i < 8; i++) s = {s, b[i] ? "1" : "0"};
        return {s, "1"};
    endfunction

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (rst) begin
            cap_len = 0;
        end else begin
            if (tx_active)   act_cnt++;
            if (tx_done)     done_cnt++;
            if (hif.overflow) ov_cnt++;
            if (tx_active && cap_len < 1024) begin
                cap[cap_len] = data_out;
                cap_len++;
            end
            if (tx_done) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame_unexpected: got a %0d-clock frame, required none", cap_len);
                end else begin
                    exp_t e;
                    int   per, bad_at;
                    e = exp_q.pop_front();
                    per = e.div + 1;
                    bad_at = -1;
                    if (cap_len == e.bits.len() * per) begin
                        for (int i = 0; i < cap_len; i++)
                            if (bad_at < 0 && cap[i] != (e.bits.getc(i / per) == "1")) bad_at = i;
                    end else bad_at = 9999;
                    if (bad_at >= 0) begin
                        n_bad++;
                        $display("FAIL frame_%s: got %0d clocks (first bad clock %0d), required %0d clocks of %s",
                                 e.name, cap_len, bad_at, e.bits.len() * per, e.bits);
                    end
                end
                cap_len = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        hif.wr_en = 1'b1;
        hif.wr_data = b;
        @(posedge clock);
        #1;
        hif.wr_en = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || tx_active) && n < budget) begin
            tick(1);
            n++;
        end
        if (exp_q.size() != 0 || tx_active) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_%s: got %0d frames still pending after %0d clocks, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic cfg(input int div, input logic [1:0] len, input logic [1:0] par, input logic st);
        baud_div = 16'(div); data_length = len; parity_type = par; stop_bits = st;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500us");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        hif.wr_en = 1'b0;
        hif.wr_data = '0;
        cfg(3, 2'b11, 2'b00, 1'b0);
        tick(3);
        check("rst_data_out", 32'(data_out), 1);
        check("rst_empty", 32'(hif.fifo_empty), 1);
        check("rst_full", 32'(hif.fifo_full), 0);
        check("rst_count", 32'(hif.fifo_count), 0);
        check("rst_active", 32'(tx_active), 0);
        check("rst_done_ovf", 32'({tx_done, hif.overflow}), 0);
        rst = 1'b0;
        tick(2);

        // 8N1, 4 clocks per bit; also checks write-to-start latency
        push_exp("A5_8N1", "0101001011", 3);
        wr(8'hA5);
        check("lat_empty_after_wr", 32'(hif.fifo_empty), 0);
        check("lat_line_idle", 32'(data_out), 1);
        tick(1);
        check("lat_line_start", 32'(data_out), 0);
        check("lat_active", 32'(tx_active), 1);
        check("lat_empty_after_pop", 32'(hif.fifo_empty), 1);
        wait_done("A5", 200);
        check("t1_empty", 32'(hif.fifo_empty), 1);

        // 7E2 and 7O2, 1 clock per bit
        cfg(0, 2'b10, 2'b10, 1'b1);
        push_exp("41_7E2", "01000001011", 0);
        wr(8'h41);
        wait_done("41E", 100);
        parity_type = 2'b01;
        push_exp("41_7O2", "01000001111", 0);
        wr(8'h41);
        wait_done("41O", 100);

        // 5O1; config scrambled mid-frame must not affect the frame
        cfg(1, 2'b00, 2'b01, 1'b0);
        push_exp("FF_5O1", "01111101", 1);
        wr(8'hFF);
        tick(2);
        cfg(7, 2'b11, 2'b00, 1'b1);
        wait_done("FF", 100);

        // three back-to-back 8N1 frames
        cfg(2, 2'b11, 2'b00, 1'b0);
        act_cnt = 0; done_cnt = 0;
        push_exp("00_8N1", "0000000001", 2);
        push_exp("FF_8N1", "0111111111", 2);
        push_exp("3C_8N1", "0001111001", 2);
        wr(8'h00); wr(8'hFF); wr(8'h3C);
        wait_done("b2b", 400);
        check("b2b_active_clocks", 32'(act_cnt), 90);
        check("b2b_done_pulses", 32'(done_cnt), 3);

        // fill: first byte popped at once, 16 more fill, the 18th overflows
        cfg(3, 2'b11, 2'b00, 1'b0);
        ov_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 17) push_exp($sformatf("fill%0d", i), frame8n1(8'h30 + 8'(i)), 3);
            wr(8'h30 + 8'(i));
        end
        check("fill_full", 32'(hif.fifo_full), 1);
        check("fill_count", 32'(hif.fifo_count), 16);
        check("fill_ovf_pulse", 32'(hif.overflow), 1);
        tick(1);
        check("fill_ovf_clear", 32'(hif.overflow), 0);
        wait_done("fill", 900);
        check("fill_ovf_count", 32'(ov_cnt), 1);
        check("fill_empty", 32'(hif.fifo_empty), 1);

        // reset in the middle of DATA
        push_exp("rst_mid", "0000000001", 3);
        wr(8'h00); wr(8'h00); wr(8'h00);
        tick(5);
        check("mid_line_low", 32'(data_out), 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_line", 32'(data_out), 1);
        check("mid_rst_count", 32'(hif.fifo_count), 0);
        check("mid_rst_active", 32'(tx_active), 0);
        exp_q.delete();
        tick(1);
        rst = 1'b0;
        act_cnt = 0;
        tick(20);
        check("post_rst_idle", 32'(act_cnt), 0);
        check("post_rst_line", 32'(data_out), 1);
        push_exp("A5_after_rst", "0101001011", 3);
        wr(8'hA5);
        wait_done("after_rst", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
